regfile_sb: RTL and testbench
=============================

# regfile_sb

Architectural register file for the processor: 32 × 32-bit registers plus a per-register pending scoreboard. It sits directly downstream of the 5-to-32 write-address decode, and its one-hot write enables come from `decoder_32`. It provides two combinational read ports with same-cycle write bypass, and tracks destinations of in-flight instructions so issue logic can stall on RAW hazards.

## Interface
Parameters:
- `DATA_W`, 32, register width. The register count is fixed at 32 and the address width at 5.

Ports:
- `clock`  in  1  rising-edge clock
- `reset_n`  in  1  reset; asynchronous, active-low
- `ctrl_writeEnable`  in  1  writeback valid
- `ctrl_writeReg`  in  5  writeback destination
- `data_writeReg`  in  DATA_W  writeback data
- `ctrl_readRegA`, `ctrl_readRegB`  in  5  source addresses
- `data_readRegA`, `data_readRegB`  out  DATA_W  source data
- `ctrl_issue`  in  1  an instruction with a destination is issuing
- `ctrl_issueReg`  in  5  destination of the issuing instruction
- `stall_A`, `stall_B`  out  1  source is pending and no bypass is available
- `issue_conflict`  out  1  issue rejected because of a WAW on a pending register
- `pending`  out  32  scoreboard vector, bit i means register i is pending

## Operation
- **Write:** at a rising edge with `ctrl_writeEnable`=1 and `ctrl_writeReg`≠0, the register loads `data_writeReg`. The write enable is generated by `decoder_32(ctrl_writeReg)` ANDed with `ctrl_writeEnable`.
- **Register 0:** reads as 0 at all times, is never pending, and ignores writes and issues.
- **Read:** combinational. If `ctrl_writeEnable` is 1 and `ctrl_writeReg` equals the read address (and the address is ≠0), the port outputs `data_writeReg` (bypass). Otherwise it outputs the stored value.
- **Scoreboard set:** at an edge with `ctrl_issue`=1, `ctrl_issueReg`≠0 and `issue_conflict`=0, `pending[ctrl_issueReg]` is set to 1.
- **Scoreboard clear:** at an edge with a valid write (destination ≠0), `pending[ctrl_writeReg]` is cleared.
- **Simultaneous set and clear on the same register:** the set wins, so the bit stays 1. The new producer owns the register.
- **Stall:** `stall_X` = `pending[readX]` & ~(`ctrl_writeEnable` & `ctrl_writeReg`==`readX`). It is 0 for address 0.
- **Conflict:** `issue_conflict` = `ctrl_issue` & (`ctrl_issueReg`≠0) & `pending[ctrl_issueReg]` & ~(write clearing that same register this cycle). While it is asserted the scoreboard is unchanged; upstream must hold and re-present the issue.
- **Pending:** the `pending` output is the registered scoreboard, bit 0 hardwired to 0.

## Timing
- **Reset:** while `reset_n`=0, all registers and all pending bits are 0 immediately, without waiting for a clock edge. This holds mid-operation, and any write or issue in that cycle is discarded.
- **Outputs during reset:** `data_read*`=0 and `stall_*`=0 when no write is presented. `issue_conflict`=0 and `pending`=0.
- **Write latency:** 1 edge to storage. Read-after-write through the bypass is visible in the same cycle.
- **Scoreboard latency:** set and clear become visible in `pending` and `stall_*` the cycle after the edge. Clear is visible in `stall_*` in the same cycle through the bypass term.
- **Combinational paths:** all read, stall and conflict outputs are combinational from current inputs and state. There are no other pipeline stages.

## Structure
- **Shared package (`proc_pkg`):**
  - `REG_ADDR_W`=5 and `NUM_REGS`=32
  - typedef `reg_addr_t`
  - constant `ZERO_REG`=0
- **Sub-module `regfile_reg32`:** one `DATA_W` register with async active-low clear and write enable. Instantiate 31 of them (indices 1..31) in a generate loop.
- **Write decode:** reuse `decoder_32`.
- **Read muxing:** two 32:1 read muxes, plus bypass comparators and scoreboard logic inside `regfile_sb`.

## Test plan
- **Reset, write, read:** release reset, write r5=0xDEADBEEF → r5 reads 0xDEADBEEF from the next cycle. In the write cycle itself, reading r5 on port A returns 0xDEADBEEF via bypass.
- **Register 0:** write r0=0xFFFFFFFF and issue r0 → reads return 0, `pending`[0]=0, `stall_*`=0, `issue_conflict`=0.
- **RAW stall:**
  - issue r7 → next cycle `pending`[7]=1, and reading r7 gives `stall_A`=1
  - in the writeback cycle (write r7=0x12) → `stall_A`=0 with data 0x12
  - the following cycle → `pending`[7]=0
- **WAW conflict:**
  - issue r3 again while r3 is pending and no write occurs → `issue_conflict`=1 and `pending` is unchanged
  - same issue while r3 is being written → `issue_conflict`=0 and `pending`[3] stays 1
- **Async reset mid-operation:** with r9=0x55 and `pending`[9]=1, pull `reset_n` low between edges → r9 reads 0 and `pending`=0 before the next edge. A write presented in that cycle is not stored.
- **Dual port:** `readRegA`=readRegB=r12=0xA5A5 → both ports return 0xA5A5. Then read r12 and r13 during a write to r13 → port A returns the stored r12, port B returns the bypassed data.

Source files
------------

// File: rtl/proc_pkg.sv
// proc_pkg: shared register-file addressing constants and types
package proc_pkg;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS = 32;
    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    localparam reg_addr_t ZERO_REG = reg_addr_t'(0);
endpackage

// File: rtl/decoder_32.sv
// decoder_32: 5-to-32 one-hot register address decoder
module decoder_32
    import proc_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] sel,
    output logic [NUM_REGS-1:0]   onehot
);
    assign onehot = NUM_REGS'(1) << sel;
endmodule

// File: rtl/regfile_reg32.sv
// regfile_reg32: one register with async active-low clear and write enable
module regfile_reg32 #(
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              we,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q
);
    // load on write enable, clear immediately on reset
    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) q <= '0;
        else if (we) q <= d;
endmodule

// File: rtl/regfile_sb.sv
// regfile_sb: 32x DATA_W register file with write bypass and pending scoreboard
module regfile_sb
    import proc_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  ctrl_writeEnable,
    input  logic [REG_ADDR_W-1:0] ctrl_writeReg,
    input  logic [DATA_W-1:0]     data_writeReg,
    input  logic [REG_ADDR_W-1:0] ctrl_readRegA,
    input  logic [REG_ADDR_W-1:0] ctrl_readRegB,
    output logic [DATA_W-1:0]     data_readRegA,
    output logic [DATA_W-1:0]     data_readRegB,
    input  logic                  ctrl_issue,
    input  logic [REG_ADDR_W-1:0] ctrl_issueReg,
    output logic                  stall_A,
    output logic                  stall_B,
    output logic                  issue_conflict,
    output logic [NUM_REGS-1:0]   pending
);
    logic [DATA_W-1:0] rf [NUM_REGS];
    logic [NUM_REGS-1:0] wr_dec, we_vec, iss_dec, set_vec, pend_q, pend_d;
    logic wr_valid, byp_a, byp_b, iss_ok;

    decoder_32 u_wdec (.sel(ctrl_writeReg), .onehot(wr_dec));
    decoder_32 u_idec (.sel(ctrl_issueReg), .onehot(iss_dec));

    assign we_vec = wr_dec & {NUM_REGS{ctrl_writeEnable}};
    assign rf[0] = '0;

    genvar g;
    for (g = 1; g < NUM_REGS; g++) begin : g_reg
        regfile_reg32 #(.DATA_W(DATA_W)) u_reg (
            .clock(clock), .reset_n(reset_n), .we(we_vec[g]), .d(data_writeReg), .q(rf[g])
        );
    end

    // read muxes with write bypass, stall/conflict detection and next scoreboard
    always_comb begin
        wr_valid = ctrl_writeEnable && ctrl_writeReg != ZERO_REG;
        byp_a = wr_valid && ctrl_writeReg == ctrl_readRegA;
        byp_b = wr_valid && ctrl_writeReg == ctrl_readRegB;
        data_readRegA = byp_a ? data_writeReg : rf[ctrl_readRegA];
        data_readRegB = byp_b ? data_writeReg : rf[ctrl_readRegB];
        stall_A = pend_q[ctrl_readRegA] && !byp_a;
        stall_B = pend_q[ctrl_readRegB] && !byp_b;
        issue_conflict = ctrl_issue && ctrl_issueReg != ZERO_REG && pend_q[ctrl_issueReg]
                         && !(wr_valid && ctrl_writeReg == ctrl_issueReg);
        iss_ok = ctrl_issue && ctrl_issueReg != ZERO_REG && !issue_conflict;
        set_vec = iss_ok ? iss_dec : '0;
        pend_d = ((pend_q & ~we_vec) | set_vec) & ~NUM_REGS'(1);
    end

    // scoreboard register; set applied after clear so a new producer wins
    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) pend_q <= '0;
        else pend_q <= pend_d;

    assign pending = pend_q;
endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: scoreboard-checked directed test of regfile_sb
module tb_regfile_sb;
    logic        clock, reset_n, ctrl_writeEnable, ctrl_issue;
    logic [4:0]  ctrl_writeReg, ctrl_readRegA, ctrl_readRegB, ctrl_issueReg;
    logic [31:0] data_writeReg, data_readRegA, data_readRegB, pending;
    logic        stall_A, stall_B, issue_conflict;

    typedef struct {
        string       nm;
        logic [31:0] a, b;
        logic        sa, sb, cf;
        logic [31:0] pd;
    } exp_t;

    exp_t q[$];
    event mon_ev;
    int n_tests = 0;
    int n_fail = 0;

    regfile_sb #(.DATA_W(32)) dut (
        .clock(clock), .reset_n(reset_n),
        .ctrl_writeEnable(ctrl_writeEnable), .ctrl_writeReg(ctrl_writeReg), .data_writeReg(data_writeReg),
        .ctrl_readRegA(ctrl_readRegA), .ctrl_readRegB(ctrl_readRegB),
        .data_readRegA(data_readRegA), .data_readRegB(data_readRegB),
        .ctrl_issue(ctrl_issue), .ctrl_issueReg(ctrl_issueReg),
        .stall_A(stall_A), .stall_B(stall_B), .issue_conflict(issue_conflict), .pending(pending)
    );

    initial clock = 0;
    always #5 clock = ~clock;

    task automatic cmp(input string nm, input string f, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s %s: got %h expected %h", nm, f, act, exp);
        end
    endtask

    // monitor: drains expected responses and compares them against the DUT outputs
    initial begin : monitor
        exp_t e;
        forever begin
            @(mon_ev);
            while (q.size() > 0) begin
                e = q.pop_front();
                cmp(e.nm, "data_A", data_readRegA, e.a);
                cmp(e.nm, "data_B", data_readRegB, e.b);
                cmp(e.nm, "stall_A", 32'(stall_A), 32'(e.sa));
                cmp(e.nm, "stall_B", 32'(stall_B), 32'(e.sb));
                cmp(e.nm, "conflict", 32'(issue_conflict), 32'(e.cf));
                cmp(e.nm, "pending", pending, e.pd);
            end
        end
    end

    task automatic drv(input logic rn, input logic we, input logic [4:0] wr, input logic [31:0] wd,
                       input logic [4:0] ra, input logic [4:0] rb, input logic iss, input logic [4:0] ir);
        @(negedge clock);
        reset_n = rn; ctrl_writeEnable = we; ctrl_writeReg = wr; data_writeReg = wd;
        ctrl_readRegA = ra; ctrl_readRegB = rb; ctrl_issue = iss; ctrl_issueReg = ir;
        #1;
    endtask

    task automatic ex(input string nm, input logic [31:0] a, input logic [31:0] b,
                      input logic sa, input logic sb, input logic cf, input logic [31:0] pd);
        q.push_back('{nm, a, b, sa, sb, cf, pd});
        -> mon_ev;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset_n = 0; ctrl_writeEnable = 0; ctrl_writeReg = 0; data_writeReg = 0;
        ctrl_readRegA = 0; ctrl_readRegB = 0; ctrl_issue = 0; ctrl_issueReg = 0;
        #2;
        ex("reset", 0, 0, 0, 0, 0, 0);
        drv(1, 1, 5, 32'hDEADBEEF, 5, 0, 0, 0);  ex("wr_r5_bypass", 32'hDEADBEEF, 0, 0, 0, 0, 0);
        drv(1, 0, 0, 0, 5, 5, 0, 0);              ex("rd_r5", 32'hDEADBEEF, 32'hDEADBEEF, 0, 0, 0, 0);
        drv(1, 1, 0, 32'hFFFFFFFF, 0, 0, 1, 0);  ex("r0_wr_iss", 0, 0, 0, 0, 0, 0);
        drv(1, 0, 0, 0, 0, 0, 0, 0);              ex("r0_after", 0, 0, 0, 0, 0, 0);
        drv(1, 0, 0, 0, 7, 0, 1, 7);              ex("iss_r7", 0, 0, 0, 0, 0, 0);
        drv(1, 0, 0, 0, 7, 0, 0, 0);              ex("raw_stall", 0, 0, 1, 0, 0, 32'h80);
        drv(1, 1, 7, 32'h12, 7, 0, 0, 0);         ex("wb_r7_bypass", 32'h12, 0, 0, 0, 0, 32'h80);
        drv(1, 0, 0, 0, 7, 0, 0, 0);              ex("r7_cleared", 32'h12, 0, 0, 0, 0, 0);
        drv(1, 0, 0, 0, 3, 0, 1, 3);              ex("iss_r3", 0, 0, 0, 0, 0, 0);
        drv(1, 0, 0, 0, 3, 0, 1, 3);              ex("waw_conflict", 0, 0, 1, 0, 1, 32'h8);
        drv(1, 0, 0, 0, 3, 0, 0, 0);              ex("waw_unchanged", 0, 0, 1, 0, 0, 32'h8);
        drv(1, 1, 3, 32'h33, 3, 0, 1, 3);         ex("waw_with_wb", 32'h33, 0, 0, 0, 0, 32'h8);
        drv(1, 0, 0, 0, 3, 0, 0, 0);              ex("set_wins", 32'h33, 0, 1, 0, 0, 32'h8);
        drv(1, 1, 3, 32'h34, 3, 0, 0, 0);         ex("wb_r3", 32'h34, 0, 0, 0, 0, 32'h8);
        drv(1, 0, 0, 0, 3, 0, 0, 0);              ex("r3_cleared", 32'h34, 0, 0, 0, 0, 0);
        drv(1, 1, 9, 32'h55, 9, 0, 1, 9);         ex("wr_iss_r9", 32'h55, 0, 0, 0, 0, 0);
        drv(1, 0, 0, 0, 9, 0, 0, 0);              ex("r9_pending", 32'h55, 0, 1, 0, 0, 32'h200);
        drv(1, 1, 10, 32'h77, 9, 10, 0, 0);       ex("pre_reset", 32'h55, 32'h77, 1, 0, 0, 32'h200);
        #1 reset_n = 0;
        #1 ex("async_reset", 0, 32'h77, 0, 0, 0, 0);
        drv(1, 0, 0, 0, 9, 10, 0, 0);             ex("post_reset", 0, 0, 0, 0, 0, 0);
        drv(1, 1, 12, 32'hA5A5, 12, 12, 0, 0);    ex("dual_bypass", 32'hA5A5, 32'hA5A5, 0, 0, 0, 0);
        drv(1, 0, 0, 0, 12, 12, 0, 0);            ex("dual_stored", 32'hA5A5, 32'hA5A5, 0, 0, 0, 0);
        drv(1, 1, 13, 32'h1313, 12, 13, 0, 0);    ex("dual_mixed", 32'hA5A5, 32'h1313, 0, 0, 0, 0);
        drv(1, 0, 0, 0, 12, 13, 1, 13);           ex("iss_r13", 32'hA5A5, 32'h1313, 0, 0, 0, 0);
        drv(1, 0, 0, 0, 12, 13, 0, 0);            ex("stall_b", 32'hA5A5, 32'h1313, 0, 1, 0, 32'h2000);
        drv(1, 1, 13, 32'h99, 12, 13, 0, 0);      ex("wb_r13", 32'hA5A5, 32'h99, 0, 0, 0, 32'h2000);
        drv(1, 0, 0, 0, 12, 13, 0, 0);            ex("r13_cleared", 32'hA5A5, 32'h99, 0, 0, 0, 0);
        #1;
        n_tests++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expected entries left, required 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
